// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with iterative unsigned MULTU/DIVU
// (one bit per cycle) and single-cycle MTHI/MTLO writes.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    state_t             state_q;
    logic [5:0]         cnt_q;
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, dividend/quotient bits}
    logic [2*WIDTH-1:0] acc_q;
    // Multiplicand for MUL, divisor for DIV
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]     div_sh_d;
    logic [WIDTH:0]     div_diff_d;
    logic [2*WIDTH-1:0] div_acc_d;
    logic               last_d;

    // One shift-add / restoring-subtract step on the current accumulator
    always_comb begin
        mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_d  = {mul_sum_d, acc_q[WIDTH-1:1]};
        div_sh_d   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_d = div_sh_d - {1'b0, opnd_q};
        if (div_diff_d[WIDTH]) begin
            div_acc_d = {div_sh_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_acc_d = {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        last_d = (cnt_q == 6'(WIDTH - 1));
    end

    // Control FSM, iteration datapath and HI/LO commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        unique case (op)
                            OP_MULTU: begin
                                opnd_q  <= SrcA;
                                acc_q   <= {{WIDTH{1'b0}}, SrcB};
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= S_MUL;
                            end
                            OP_DIVU: begin
                                opnd_q  <= SrcB;
                                acc_q   <= {{WIDTH{1'b0}}, SrcA};
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= S_DIV;
                            end
                            OP_MTHI: hi_q <= SrcA;
                            OP_MTLO: lo_q <= SrcA;
                        endcase
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (last_d) begin
                        hi_q    <= mul_acc_d[2*WIDTH-1:WIDTH];
                        lo_q    <= mul_acc_d[WIDTH-1:0];
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_DIV: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (last_d) begin
                        hi_q    <= div_acc_d[2*WIDTH-1:WIDTH];
                        lo_q    <= div_acc_d[WIDTH-1:0];
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized and directed checks of hilo_muldiv
// against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: what HI/LO must hold once an operation has completed
    function automatic void model(input logic [1:0] o,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (o)
            2'b00: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                exp_hi = p[2*W-1:W];
                exp_lo = p[W-1:0];
            end
            2'b01: begin
                if (b == 0) begin
                    exp_lo = '1;
                    exp_hi = a;
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            2'b10: exp_hi = a;
            default: exp_lo = a;
        endcase
    endfunction

    // Present one request for one edge, then scramble the don't-care inputs
    task automatic issue(input logic [1:0] o,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        SrcA  = a;
        SrcB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        SrcA  = $urandom;
        SrcB  = $urandom;
    endtask

    // Edges from acceptance until done, busy samples before it, and
    // samples where HI/LO moved away from their pre-operation values
    task automatic wait_done(output int lat, output int busy_n,
                             output int hold_bad);
        lat      = -1;
        busy_n   = 0;
        hold_bad = 0;
        for (int c = 0; c <= W + 8; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_n++;
            if (HI !== exp_hi || LO !== exp_lo) hold_bad++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        SrcA  = '0;
        SrcB  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        n_tests++;
        if (HI !== 0 || LO !== 0 || busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL reset: HI=%h LO=%h busy=%b done=%b, need all 0",
                     HI, LO, busy, done);
        end
    endtask

    task automatic test_multu();
        logic [W-1:0] da [4] = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h80000000};
        logic [W-1:0] db [4] = '{32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 32'h2};
        logic [W-1:0] a, b;
        int lat, bn, hb;
        for (int i = 0; i < 10; i++) begin
            a = (i < 4) ? da[i] : $urandom;
            b = (i < 4) ? db[i] : $urandom;
            issue(2'b00, a, b);
            wait_done(lat, bn, hb);
            model(2'b00, a, b);
            n_tests++;
            if (lat != W || bn != W || hb != 0 || busy !== 0) begin
                n_fail++;
                $display("FAIL multu_timing %h*%h: lat=%0d busy_n=%0d hold_bad=%0d busy=%b, need %0d %0d 0 0",
                         a, b, lat, bn, hb, busy, W, W);
            end
            n_tests++;
            if (HI !== exp_hi || LO !== exp_lo) begin
                n_fail++;
                $display("FAIL multu %h*%h: HI=%h LO=%h, need HI=%h LO=%h",
                         a, b, HI, LO, exp_hi, exp_lo);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (done !== 0) begin
                n_fail++;
                $display("FAIL multu_done_pulse: done=%b, need 0", done);
            end
        end
    endtask

    task automatic test_divu();
        logic [W-1:0] da [5] = '{32'd100, 32'd5, 32'hFFFFFFFF, 32'd7, 32'd0};
        logic [W-1:0] db [5] = '{32'd7, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0};
        logic [W-1:0] a, b;
        int lat, bn, hb;
        for (int i = 0; i < 12; i++) begin
            a = (i < 5) ? da[i] : $urandom;
            if (i < 5) b = db[i];
            else if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 15);
            else b = $urandom >> $urandom_range(0, 31);
            issue(2'b01, a, b);
            wait_done(lat, bn, hb);
            model(2'b01, a, b);
            n_tests++;
            if (lat != W || bn != W || hb != 0 || busy !== 0) begin
                n_fail++;
                $display("FAIL divu_timing %h/%h: lat=%0d busy_n=%0d hold_bad=%0d busy=%b, need %0d %0d 0 0",
                         a, b, lat, bn, hb, busy, W, W);
            end
            n_tests++;
            if (HI !== exp_hi || LO !== exp_lo) begin
                n_fail++;
                $display("FAIL divu %h/%h: HI=%h LO=%h, need HI=%h LO=%h",
                         a, b, HI, LO, exp_hi, exp_lo);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (done !== 0) begin
                n_fail++;
                $display("FAIL divu_done_pulse: done=%b, need 0", done);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [W-1:0] a;
        logic [1:0]   o;
        issue(2'b10, 32'h12345678, $urandom);
        model(2'b10, 32'h12345678, '0);
        n_tests++;
        if (HI !== exp_hi || LO !== exp_lo || busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL mthi: HI=%h LO=%h busy=%b done=%b, need HI=%h LO=%h 0 0",
                     HI, LO, busy, done, exp_hi, exp_lo);
        end
        issue(2'b11, 32'h9ABCDEF0, $urandom);
        model(2'b11, 32'h9ABCDEF0, '0);
        n_tests++;
        if (HI !== exp_hi || LO !== exp_lo || busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL mtlo: HI=%h LO=%h busy=%b done=%b, need HI=%h LO=%h 0 0",
                     HI, LO, busy, done, exp_hi, exp_lo);
        end
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            o = 2'($urandom_range(2, 3));
            issue(o, a, $urandom);
            model(o, a, '0);
            n_tests++;
            if (HI !== exp_hi || LO !== exp_lo || busy !== 0 || done !== 0) begin
                n_fail++;
                $display("FAIL mt_random op=%0d: HI=%h LO=%h busy=%b done=%b, need HI=%h LO=%h",
                         o, HI, LO, busy, done, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_ignore_while_busy();
        int dead_seen = 0;
        int got = 0;
        issue(2'b00, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b11;
        SrcA  = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < W + 8; c++) begin
            if (LO === 32'hDEAD) dead_seen++;
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        model(2'b00, 32'd3, 32'd5);
        n_tests++;
        if (got != 1 || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++;
            $display("FAIL ignore_result: done_seen=%0d HI=%h LO=%h, need 1 HI=%h LO=%h",
                     got, HI, LO, exp_hi, exp_lo);
        end
        repeat (3) @(posedge clk);
        #1;
        if (LO === 32'hDEAD) dead_seen++;
        n_tests++;
        if (dead_seen != 0 || LO !== exp_lo || busy !== 0) begin
            n_fail++;
            $display("FAIL ignore_mtlo: dead_seen=%0d LO=%h busy=%b, need 0 LO=%h busy=0",
                     dead_seen, LO, busy, exp_lo);
        end
    endtask

    task automatic test_reset_abort();
        int done_seen = 0;
        int lat, bn, hb;
        issue(2'b10, 32'h5A5A5A5A, '0);
        model(2'b10, 32'h5A5A5A5A, '0);
        issue(2'b00, 32'h10000, 32'h10000);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        n_tests++;
        if (HI !== 0 || LO !== 0 || busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL abort_reset: HI=%h LO=%h busy=%b done=%b, need all 0",
                     HI, LO, busy, done);
        end
        for (int c = 0; c < W + 4; c++) begin
            if (done !== 0 || HI !== 0 || LO !== 0 || busy !== 0) done_seen++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d bad cycles after abort, need 0",
                     done_seen);
        end
        issue(2'b00, 32'h10000, 32'h10000);
        wait_done(lat, bn, hb);
        model(2'b00, 32'h10000, 32'h10000);
        n_tests++;
        if (lat != W || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++;
            $display("FAIL abort_reissue: lat=%0d HI=%h LO=%h, need %0d HI=%h LO=%h",
                     lat, HI, LO, W, exp_hi, exp_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int lat, bn, hb;
        issue(2'b01, 32'd9, 32'd2);
        wait_done(lat, bn, hb);
        model(2'b01, 32'd9, 32'd2);
        n_tests++;
        if (lat != W || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++;
            $display("FAIL b2b_div: lat=%0d HI=%h LO=%h, need %0d HI=%h LO=%h",
                     lat, HI, LO, W, exp_hi, exp_lo);
        end
        issue(2'b10, 32'hAAAA, '0);
        model(2'b10, 32'hAAAA, '0);
        n_tests++;
        if (HI !== exp_hi || LO !== exp_lo || busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL b2b_mthi: HI=%h LO=%h busy=%b done=%b, need HI=%h LO=%h 0 0",
                     HI, LO, busy, done, exp_hi, exp_lo);
        end
        a = $urandom;
        b = $urandom;
        issue(2'b00, a, b);
        wait_done(lat, bn, hb);
        model(2'b00, a, b);
        a = $urandom;
        b = $urandom_range(1, 1000);
        issue(2'b01, a, b);
        n_tests++;
        if (busy !== 1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b after issue in done cycle, need 1",
                     busy);
        end
        wait_done(lat, bn, hb);
        model(2'b01, a, b);
        n_tests++;
        if (lat != W || bn != W || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++;
            $display("FAIL b2b_muldiv: lat=%0d busy_n=%0d HI=%h LO=%h, need %0d %0d HI=%h LO=%h",
                     lat, bn, HI, LO, W, W, exp_hi, exp_lo);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit that owns the HI/LO register pair. It sits upstream of the ALU and supplies the ALU's `LO`/`HI` operands for MFHI/MFLO. It executes MULTU and DIVU over multiple cycles, and MTHI/MTLO in a single cycle. A `busy` output tells the pipeline controller to stall any instruction that touches HI/LO until the result is committed.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request strobe, sampled on the rising edge.
- `op`, in, 2: operation code.
  - 2'b00 MULTU
  - 2'b01 DIVU
  - 2'b10 MTHI
  - 2'b11 MTLO
- `SrcA`, in, WIDTH: multiplicand / dividend / MTHI-MTLO data.
- `SrcB`, in, WIDTH: multiplier / divisor.
- `HI`, out, WIDTH: HI register; feeds the ALU `HI` input.
- `LO`, out, WIDTH: LO register; feeds the ALU `LO` input.
- `busy`, out, 1: a multi-cycle operation is in flight.
- `done`, out, 1: one-cycle pulse when a MULTU/DIVU result is committed.

## Operation
- States: IDLE, MUL, DIV. Registered 6-bit iteration counter `cnt`.
- In IDLE with `start`=1:
  - MULTU: latch operands into internal registers, clear accumulator, `cnt`<=0, go to MUL.
  - DIVU: latch operands into internal registers, clear partial remainder, `cnt`<=0, go to DIV.
  - MTHI: HI<=SrcA, LO unchanged, remain IDLE. No `done` pulse.
  - MTLO: LO<=SrcA, HI unchanged, remain IDLE. No `done` pulse.
- MUL, unsigned shift-add, one multiplier bit per cycle (LSB first):
  - If the current multiplier bit is 1, add the multiplicand to the upper half of the 2·WIDTH accumulator.
  - Shift the accumulator right one bit, keeping the carry.
- DIV, unsigned restoring division, one quotient bit per cycle (MSB first):
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor from the remainder using WIDTH+1 bits.
  - If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
- After iteration `cnt`==WIDTH-1:
  - MUL commits HI<=product[2W-1:W], LO<=product[W-1:0].
  - DIV commits LO<=quotient, HI<=remainder.
  - Both pulse `done` and return to IDLE.
- Divide by zero (`SrcB`==0 at start) is not special-cased. The algorithm naturally yields LO=all ones and HI=SrcA; this is the required result. It takes the normal WIDTH cycles.
- `start` while `busy`=1 is ignored (no queueing, operands not re-latched). The controller must hold the request until `busy`=0.
- `op` and `SrcA`/`SrcB` are don't-care when `start`=0.
- All arithmetic is unsigned, modulo 2^(2·WIDTH) for the product. No overflow flags.

## Timing
- Reset values: HI=0, LO=0, busy=0, done=0, state=IDLE, cnt=0.
- `reset` asserted mid-operation aborts it on that edge:
  - HI/LO are cleared and no partial result is committed.
  - `done` is not pulsed.
- Registered outputs; no combinational path from inputs to any output.
- MTHI/MTLO accepted at edge E: new value visible on HI/LO in the cycle after E. Total latency 1.
- MULTU/DIVU accepted at edge E:
  - `busy`=1 for the WIDTH cycles following E.
  - The commit occurs on edge E+WIDTH.
  - In the cycle after E+WIDTH: HI/LO show the result, `done`=1, and `busy`=0.
  - Result latency is WIDTH+1 cycles; 33 for WIDTH=32.
- `done` is high for exactly one cycle per MULTU/DIVU.
- A new `start` is accepted in the same cycle `done` is high (back-to-back issue). The MTHI/MTLO case is covered by the Test plan.
- `start` with MTHI/MTLO on the commit edge cannot occur, because the unit is busy on that edge; the request is ignored by rule.
- HI/LO hold their previous values for the whole busy period; an MFHI during busy must be stalled by the controller.

## Test plan
- Reset, then MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy for 32 cycles; cycle 33: HI=0xFFFFFFFE, LO=0x00000001, done=1 for one cycle.
- DIVU A=100, B=7 -> after 33 cycles LO=14, HI=2. Then DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5.
- MTHI 0x12345678, next cycle MTLO 0x9ABCDEF0 -> HI=0x12345678 one cycle after the first, LO=0x9ABCDEF0 one cycle after the second; done never asserted, busy stays 0.
- MULTU 3×5 started; at busy cycle 10 pulse start with MTLO 0xDEAD -> ignored; final HI=0, LO=15; LO never equals 0xDEAD.
- MULTU 0x10000×0x10000 started; reset asserted at busy cycle 20 -> next cycle HI=0, LO=0, busy=0, no done pulse. Reissue after reset -> HI=1, LO=0.
- Back-to-back: DIVU 9/2 with a MTHI 0xAAAA start issued in the done cycle -> LO=4, HI=1, then HI=0xAAAA one cycle later, LO still 4.
